// File: rtl/lsu_arb.sv
// Load/store arbiter: N_CH requesters share an SRAM port and an AXI master port,
// with in-order response routing. Optional request locking via LSU_LOCK_EN.
module lsu_arb #(
    parameter int          N_CH      = 3,
    parameter int          OUTST     = 2,
    parameter int          ARB_MODE  = 0,
    parameter logic [15:0] SRAM_BASE = 16'h8000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_CH-1:0]      hs_req_val,
    output logic [N_CH-1:0]      hs_req_rdy,
    input  logic [N_CH*32-1:0]   i_req_adr,
    input  logic [N_CH*32-1:0]   i_req_wdat,
    input  logic [N_CH*4-1:0]    i_req_wen,
    input  logic [N_CH-1:0]      i_req_ren,
`ifdef LSU_LOCK_EN
    input  logic [N_CH-1:0]      i_req_lock,
`endif
    output logic [N_CH-1:0]      o_rsp_val,
    output logic [31:0]          o_rsp_rdat,
    output logic [31:0]          o_adr,
    output logic [31:0]          o_wdat,
    output logic                 hs_ls4ram_val,
    input  logic                 hs_ram4ls_rdy,
    output logic [3:0]           o_sram_wen,
    output logic                 o_sram_ren,
    input  logic                 i_sram_rvld,
    input  logic [31:0]          i_sram_rdat,
    output logic                 hs_ls4axim_val,
    input  logic                 hs_axim4ls_rdy,
    output logic [3:0]           o_axim_wen,
    output logic                 o_axim_ren,
    input  logic                 i_axim_rvld,
    input  logic [31:0]          i_axim_rdat
);
    localparam int CW = $clog2(N_CH);
    localparam int PW = (OUTST > 1) ? $clog2(OUTST) : 1;
    localparam int NW = $clog2(OUTST + 1);

    // Tracker entry target: 0 = SRAM, 1 = AXI
    logic [OUTST-1:0][CW-1:0] id_q;
    logic [OUTST-1:0]         tgt_q;
    logic [PW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
    logic [NW-1:0]            cnt_q, cnt_d;
    logic [CW-1:0]            rr_q, rr_d;
    logic                     tail_tgt_q;

    logic [CW-1:0] win;
    logic          any, win_tgt, head_tgt, pop, full, issue, accept, rr_hold;
    logic [31:0]   adr_w, wdat_w;
    logic [3:0]    wen_w;
    logic          ren_w;

    function automatic logic [CW-1:0] wrap_add(input logic [CW-1:0] b, input int i);
        int s;
        s = int'(b) + i;
        if (s >= N_CH) s = s - N_CH;
        return CW'(s);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTST - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef LSU_LOCK_EN
    logic          lock_q;
    logic [CW-1:0] lock_ch_q;
    logic          pinned;
    assign pinned  = lock_q && hs_req_val[lock_ch_q];
    assign rr_hold = pinned || i_req_lock[win];
`else
    assign rr_hold = 1'b0;
`endif

    always_comb begin
        win = '0;
        any = 1'b0;
        if (ARB_MODE == 0) begin
            for (int k = 0; k < N_CH; k++)
                if (hs_req_val[k]) begin
                    win = CW'(k);
                    any = 1'b1;
                end
        end else begin
            for (int i = 0; i < N_CH; i++)
                if (!any && hs_req_val[wrap_add(rr_q, i)]) begin
                    win = wrap_add(rr_q, i);
                    any = 1'b1;
                end
        end
`ifdef LSU_LOCK_EN
        if (pinned) begin
            win = lock_ch_q;
            any = 1'b1;
        end
`endif
    end

    assign adr_w   = i_req_adr[win*32 +: 32];
    assign wdat_w  = i_req_wdat[win*32 +: 32];
    assign wen_w   = i_req_wen[win*4 +: 4];
    assign ren_w   = i_req_ren[win];
    assign win_tgt = (adr_w[31:16] != SRAM_BASE);

    assign head_tgt = tgt_q[rptr_q];
    assign pop      = !i_rst && (cnt_q != '0) && (head_tgt ? i_axim_rvld : i_sram_rvld);
    // A pop in the same cycle frees a slot, so a full tracker can still accept.
    assign full     = (cnt_q == NW'(OUTST)) && !pop;
    assign issue    = !i_rst && any && !full && (cnt_q == '0 || win_tgt == tail_tgt_q);
    assign accept   = issue && (win_tgt ? hs_axim4ls_rdy : hs_ram4ls_rdy);

    assign hs_req_rdy     = accept ? (N_CH'(1) << win) : '0;
    assign o_rsp_val      = pop ? (N_CH'(1) << id_q[rptr_q]) : '0;
    assign o_rsp_rdat     = pop ? (head_tgt ? i_axim_rdat : i_sram_rdat) : '0;
    assign o_adr          = issue ? adr_w : '0;
    assign o_wdat         = issue ? wdat_w : '0;
    assign hs_ls4ram_val  = issue && !win_tgt;
    assign o_sram_wen     = hs_ls4ram_val ? wen_w : '0;
    assign o_sram_ren     = hs_ls4ram_val && ren_w;
    assign hs_ls4axim_val = issue && win_tgt;
    assign o_axim_wen     = hs_ls4axim_val ? wen_w : '0;
    assign o_axim_ren     = hs_ls4axim_val && ren_w;

    always_comb begin
        wptr_d = accept ? ptr_inc(wptr_q) : wptr_q;
        rptr_d = pop ? ptr_inc(rptr_q) : rptr_q;
        cnt_d  = cnt_q;
        if (accept && !pop) cnt_d = cnt_q + 1'b1;
        if (!accept && pop) cnt_d = cnt_q - 1'b1;
        rr_d   = (accept && !rr_hold) ? wrap_add(win, 1) : rr_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            rr_q       <= '0;
            tail_tgt_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            rr_q   <= rr_d;
            if (accept) begin
                id_q[wptr_q]  <= win;
                tgt_q[wptr_q] <= win_tgt;
                tail_tgt_q    <= win_tgt;
            end
        end
    end

`ifdef LSU_LOCK_EN
    // Lock is taken or released by each accept; dropping val also releases it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lock_q    <= 1'b0;
            lock_ch_q <= '0;
        end else if (accept) begin
            lock_q    <= i_req_lock[win];
            lock_ch_q <= win;
        end else if (lock_q && !hs_req_val[lock_ch_q]) begin
            lock_q <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_lsu_arb.sv
// Directed bench for lsu_arb: fixed-priority and round-robin instances share stimulus.
module tb_lsu_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  val, ren;
    logic [95:0] adr, wdat;
    logic [11:0] wen;
    logic        ram_rdy, sram_rvld, axim_rdy, axim_rvld;
    logic [31:0] sram_rdat, axim_rdat;
`ifdef LSU_LOCK_EN
    logic [2:0]  lock;
`endif

    logic [2:0]  rdy_f, rsp_f, rdy_r, rsp_r;
    logic [31:0] rdat_f, adr_f, wdat_f, rdat_r, adr_r, wdat_r;
    logic        sval_f, sren_f, aval_f, aren_f, sval_r, sren_r, aval_r, aren_r;
    logic [3:0]  swen_f, awen_f, swen_r, awen_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_arb #(.N_CH(3), .OUTST(2), .ARB_MODE(0), .SRAM_BASE(16'h8000)) u_fp (
        .i_clk(clk), .i_rst(rst), .hs_req_val(val), .hs_req_rdy(rdy_f),
        .i_req_adr(adr), .i_req_wdat(wdat), .i_req_wen(wen), .i_req_ren(ren),
`ifdef LSU_LOCK_EN
        .i_req_lock(lock),
`endif
        .o_rsp_val(rsp_f), .o_rsp_rdat(rdat_f), .o_adr(adr_f), .o_wdat(wdat_f),
        .hs_ls4ram_val(sval_f), .hs_ram4ls_rdy(ram_rdy), .o_sram_wen(swen_f),
        .o_sram_ren(sren_f), .i_sram_rvld(sram_rvld), .i_sram_rdat(sram_rdat),
        .hs_ls4axim_val(aval_f), .hs_axim4ls_rdy(axim_rdy), .o_axim_wen(awen_f),
        .o_axim_ren(aren_f), .i_axim_rvld(axim_rvld), .i_axim_rdat(axim_rdat));

    lsu_arb #(.N_CH(3), .OUTST(2), .ARB_MODE(1), .SRAM_BASE(16'h8000)) u_rr (
        .i_clk(clk), .i_rst(rst), .hs_req_val(val), .hs_req_rdy(rdy_r),
        .i_req_adr(adr), .i_req_wdat(wdat), .i_req_wen(wen), .i_req_ren(ren),
`ifdef LSU_LOCK_EN
        .i_req_lock(lock),
`endif
        .o_rsp_val(rsp_r), .o_rsp_rdat(rdat_r), .o_adr(adr_r), .o_wdat(wdat_r),
        .hs_ls4ram_val(sval_r), .hs_ram4ls_rdy(ram_rdy), .o_sram_wen(swen_r),
        .o_sram_ren(sren_r), .i_sram_rvld(sram_rvld), .i_sram_rdat(sram_rdat),
        .hs_ls4axim_val(aval_r), .hs_axim4ls_rdy(axim_rdy), .o_axim_wen(awen_r),
        .o_axim_ren(aren_r), .i_axim_rvld(axim_rvld), .i_axim_rdat(axim_rdat));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs set afterwards settle before checks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        val = '0; ren = '0; adr = '0; wdat = '0; wen = '0;
        ram_rdy = 1'b1; axim_rdy = 1'b1; sram_rvld = 1'b0; axim_rvld = 1'b0;
        sram_rdat = '0; axim_rdat = '0;
`ifdef LSU_LOCK_EN
        lock = '0;
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic all_adr(input logic [31:0] a);
        adr = {a, a, a};
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        // Requests and responses presented during reset must be ignored
        val = 3'b111; all_adr(32'h8000_0010); sram_rvld = 1'b1; settle();
        check("rst_rdy", rdy_f, 3'b000);
        check("rst_sval", sval_f, 1'b0);
        check("rst_adr", adr_f, 32'h0);
        check("rst_rsp", rsp_f, 3'b000);
        do_reset();

        // Fixed priority
        val = 3'b111; all_adr(32'h8000_0010); settle();
        check("fp_rdy_all", rdy_f, 3'b100);
        check("fp_sval", sval_f, 1'b1);
        check("fp_adr", adr_f, 32'h8000_0010);
        check("fp_aval", aval_f, 1'b0);
        tick();
        val = 3'b011; sram_rvld = 1'b1; settle();
        check("fp_rdy_drop2", rdy_f, 3'b010);
        check("fp_rsp", rsp_f, 3'b100);
        do_reset();

        // Round robin with one-cycle response echo
        val = 3'b111; all_adr(32'h8000_0010); settle();
        check("rr_g0", rdy_r, 3'b001);
        tick();
        sram_rvld = 1'b1; settle();
        check("rr_g1", rdy_r, 3'b010);
        check("rr_rsp0", rsp_r, 3'b001);
        tick(); settle();
        check("rr_g2", rdy_r, 3'b100);
        check("rr_rsp1", rsp_r, 3'b010);
        tick(); settle();
        check("rr_g0b", rdy_r, 3'b001);
        check("rr_rsp2", rsp_r, 3'b100);
        do_reset();

        // Target switch stall
        val = 3'b001; adr[31:0] = 32'h8000_0000; ren = 3'b001; settle();
        check("ts_sram_acc", rdy_f, 3'b001);
        check("ts_sren", sren_f, 1'b1);
        tick();
        val = 3'b010; adr[63:32] = 32'h1000_0000; ren = 3'b010; settle();
        check("ts_stall_aval", aval_f, 1'b0);
        check("ts_stall_rdy", rdy_f, 3'b000);
        check("ts_stall_adr", adr_f, 32'h0);
        tick(); settle();
        check("ts_stall2_aval", aval_f, 1'b0);
        tick();
        sram_rvld = 1'b1; settle();
        check("ts_pop_rsp", rsp_f, 3'b001);
        check("ts_pop_aval", aval_f, 1'b0);
        tick();
        sram_rvld = 1'b0; settle();
        check("ts_axi_aval", aval_f, 1'b1);
        check("ts_axi_rdy", rdy_f, 3'b010);
        check("ts_axi_adr", adr_f, 32'h1000_0000);
        check("ts_axi_ren", aren_f, 1'b1);
        check("ts_axi_sval", sval_f, 1'b0);
        do_reset();

        // Tracker full with pop-through
        all_adr(32'h8000_0020);
        val = 3'b001; settle();
        check("tf_acc0", rdy_f, 3'b001);
        tick();
        val = 3'b010; settle();
        check("tf_acc1", rdy_f, 3'b010);
        tick();
        val = 3'b100; settle();
        check("tf_full_rdy", rdy_f, 3'b000);
        check("tf_full_sval", sval_f, 1'b0);
        tick();
        sram_rvld = 1'b1; settle();
        check("tf_pt_rsp", rsp_f, 3'b001);
        check("tf_pt_rdy", rdy_f, 3'b100);
        tick();
        sram_rvld = 1'b0; val = 3'b001; settle();
        check("tf_still_full", rdy_f, 3'b000);
        tick();
        sram_rvld = 1'b1; val = 3'b000; settle();
        check("tf_order_rsp", rsp_f, 3'b010);
        do_reset();

        // Response routing and spurious responses
        val = 3'b100; adr[95:64] = 32'h8000_0004; ren = 3'b100; settle();
        check("rt_acc", rdy_f, 3'b100);
        tick();
        val = 3'b000; ren = 3'b000; sram_rvld = 1'b1; sram_rdat = 32'hDEAD_BEEF; settle();
        check("rt_rsp", rsp_f, 3'b100);
        check("rt_rdat", rdat_f, 32'hDEAD_BEEF);
        check("rt_adr0", adr_f, 32'h0);
        check("rt_rdy0", rdy_f, 3'b000);
        tick();
        sram_rvld = 1'b0; settle();
        check("rt_rdat_idle", rdat_f, 32'h0);
        sram_rvld = 1'b1; axim_rvld = 1'b1; axim_rdat = 32'h1234_5678; settle();
        check("rt_spur_rsp", rsp_f, 3'b000);
        check("rt_spur_rdat", rdat_f, 32'h0);
        do_reset();

        // Write issue, then reset with an entry outstanding
        val = 3'b010; adr[63:32] = 32'h8000_0008; wdat[63:32] = 32'hCAFE_0001;
        wen[7:4] = 4'hA; settle();
        check("wr_rdy", rdy_f, 3'b010);
        check("wr_swen", swen_f, 4'hA);
        check("wr_wdat", wdat_f, 32'hCAFE_0001);
        check("wr_awen", awen_f, 4'h0);
        check("wr_sren", sren_f, 1'b0);
        tick();
        val = 3'b000; wen = '0; rst = 1'b1; tick();
        rst = 1'b0; sram_rvld = 1'b1; settle();
        check("rst_late_rsp", rsp_f, 3'b000);
        check("rst_late_rdat", rdat_f, 32'h0);
        do_reset();

`ifdef LSU_LOCK_EN
        all_adr(32'h8000_0030);
        val = 3'b001; lock = 3'b001; settle();
        check("lk_take", rdy_f, 3'b001);
        tick();
        val = 3'b101; sram_rvld = 1'b1; settle();
        check("lk_pinned", rdy_f, 3'b001);
        tick();
        lock = 3'b000; settle();
        check("lk_release", rdy_f, 3'b001);
        tick(); settle();
        check("lk_free", rdy_f, 3'b100);
        do_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
